// File: rtl/button_press_decoder.sv
// button_press_decoder: classifies debounced button gestures into short, long and double press pulses
module button_press_decoder #(
  parameter int LONG_CYCLES = 16,
  parameter int DBL_GAP     = 8,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sigIn,
  output logic pressed,
  output logic shortPress,
  output logic longPress,
  output logic doublePress
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESS1    = 3'd1;
  localparam logic [2:0] WAIT_GAP  = 3'd2;
  localparam logic [2:0] PRESS2    = 3'd3;
  localparam logic [2:0] LONG_HOLD = 3'd4;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(DBL_GAP);
  logic [2:0] state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic short_n, long_n, double_n;
  assign cnt_inc = cnt + CNT_ONE;
  // Next-state, shared counter and pulse decode; pulses are only ever raised on a transition out of a state
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;
    case (state)
      IDLE: begin
        if (sigIn) begin
          state_n = PRESS1;
          cnt_n   = CNT_ONE;
        end
      end
      PRESS1: begin
        if (!sigIn) begin
          state_n = WAIT_GAP;
          cnt_n   = CNT_ONE;
        end else if (cnt_inc == LONG_C) begin
          long_n  = 1'b1;
          state_n = LONG_HOLD;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      WAIT_GAP: begin
        if (sigIn) begin
          state_n = PRESS2;
          cnt_n   = '0;
        end else if (cnt_inc == GAP_C) begin
          short_n = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      PRESS2: begin
        if (!sigIn) begin
          double_n = 1'b1;
          state_n  = IDLE;
          cnt_n    = '0;
        end
      end
      LONG_HOLD: begin
        if (!sigIn) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  // State, counter and registered outputs; reset aborts any gesture without a pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pressed     <= 1'b0;
      shortPress  <= 1'b0;
      longPress   <= 1'b0;
      doublePress <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pressed     <= sigIn;
      shortPress  <= short_n;
      longPress   <= long_n;
      doublePress <= double_n;
    end
  end
endmodule

// File: tb/tb_button_press_decoder.sv
// tb_button_press_decoder: directed gesture sequences with hand-computed pulse counts and positions
module tb_button_press_decoder;
  logic clk, rst, sigIn;
  logic pressed, shortPress, longPress, doublePress;
  int total = 0, bad = 0;
  int t = 0, cs, cl, cd, cp, multi, ps, pl, pd, t0;
  button_press_decoder #(.LONG_CYCLES(16), .DBL_GAP(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sigIn(sigIn), .pressed(pressed),
    .shortPress(shortPress), .longPress(longPress), .doublePress(doublePress)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clr();
    cs = 0; cl = 0; cd = 0; cp = 0; multi = 0; ps = -1; pl = -1; pd = -1;
  endtask
  // one sample per clock; outputs observed 1 ns after the edge that sampled the step
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      sigIn = v;
      @(posedge clk);
      #1;
      t++;
      if (shortPress) begin cs++; ps = t; end
      if (longPress) begin cl++; pl = t; end
      if (doublePress) begin cd++; pd = t; end
      if (pressed) cp++;
      if (32'(shortPress) + 32'(longPress) + 32'(doublePress) > 1) multi++;
    end
  endtask
  initial begin
    rst = 1'b0;
    sigIn = 1'b0;
    clr();
    // reset held with a toggling input
    drive(1, 1); drive(0, 1); drive(1, 2); drive(0, 1); drive(1, 1);
    chk("rst_pressed", cp, 0);
    chk("rst_pulses", cs + cl + cd, 0);
    drive(0, 1);
    rst = 1'b1;
    drive(0, 20);
    chk("post_rst_pulses", cs + cl + cd, 0);
    // short press of 5
    clr();
    drive(1, 1);
    chk("pressed_follows", 32'(pressed), 1);
    drive(1, 4);
    t0 = t;
    drive(0, 12);
    chk("short_cnt", cs, 1);
    chk("short_pos", ps, t0 + 8);
    chk("short_no_other", cl + cd, 0);
    chk("short_pressed_len", cp, 5);
    // long press of 20
    clr();
    t0 = t;
    drive(1, 20);
    drive(0, 20);
    chk("long_cnt", cl, 1);
    chk("long_pos", pl, t0 + 16);
    chk("long_no_short", cs + cd, 0);
    // 15 samples is still short
    clr();
    drive(1, 15);
    t0 = t;
    drive(0, 12);
    chk("p15_short", cs, 1);
    chk("p15_pos", ps, t0 + 8);
    chk("p15_no_long", cl, 0);
    // double press
    clr();
    drive(1, 4); drive(0, 3); drive(1, 4);
    t0 = t;
    drive(0, 12);
    chk("dbl_cnt", cd, 1);
    chk("dbl_pos", pd, t0 + 1);
    chk("dbl_no_short", cs + cl, 0);
    // gap of exactly 8: two shorts
    clr();
    drive(1, 4); drive(0, 8); drive(1, 4); drive(0, 10);
    chk("gap8_short", cs, 2);
    chk("gap8_no_dbl", cd, 0);
    // gap of 7: double
    clr();
    drive(1, 4); drive(0, 7); drive(1, 4); drive(0, 10);
    chk("gap7_dbl", cd, 1);
    chk("gap7_no_short", cs, 0);
    // reset inside WAIT_GAP
    clr();
    drive(1, 4); drive(0, 3);
    rst = 1'b0;
    #1;
    chk("rst_async_pressed", 32'(pressed), 0);
    drive(0, 2);
    rst = 1'b1;
    drive(0, 12);
    chk("midrst_no_pulse", cs + cl + cd, 0);
    clr();
    drive(1, 4); drive(0, 12);
    chk("midrst_after_short", cs, 1);
    chk("midrst_after_other", cl + cd, 0);
    chk("onehot", multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_press_decoder.md
Name: button_press_decoder

Overview:
- Consumes the clean single-bit level produced by the debounce stage.
- Classifies each button gesture as a short press, a long press or a double press.
- Emits one single-cycle pulse per classified gesture, plus a registered copy of the held level.
- Sits between the debounce stage and the control logic that reacts to user input.

Parameters:
LONG_CYCLES, 16, number of consecutive high samples that classifies a press as long; must be >= 2
DBL_GAP, 8, number of consecutive low samples after a first short press that ends the double-press window; must be >= 2
CNT_W, 8, counter width; must hold max(LONG_CYCLES, DBL_GAP)

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous active-low reset
sigIn  input  1  debounced button level, already synchronous to clk; 1 = pressed
pressed  output  1  sigIn registered once (one-cycle delay)
shortPress  output  1  one-cycle pulse: short press, no second press in the window
longPress  output  1  one-cycle pulse: press held LONG_CYCLES samples
doublePress  output  1  one-cycle pulse: second press released inside the window

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, all outputs 0. Release is synchronous to clk.
- Outputs are registered. At most one of shortPress/longPress/doublePress is high in any cycle, and each pulse lasts exactly one cycle.
- States: IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HOLD. A single counter, cnt, is reused across states.
- IDLE:
  - sigIn=1 -> PRESS1, cnt<=1.
  - sigIn=0 -> stay.
- PRESS1:
  - sigIn=1 and cnt+1==LONG_CYCLES -> longPress<=1, go to LONG_HOLD.
  - sigIn=1 otherwise -> cnt<=cnt+1.
  - sigIn=0 -> WAIT_GAP, cnt<=1.
- WAIT_GAP:
  - sigIn=0 and cnt+1==DBL_GAP -> shortPress<=1, go to IDLE, cnt<=0.
  - sigIn=0 otherwise -> cnt<=cnt+1.
  - sigIn=1 -> PRESS2, cnt<=0.
- PRESS2:
  - No counting; the duration of the second press is ignored.
  - sigIn=0 -> doublePress<=1, go to IDLE.
- LONG_HOLD:
  - Wait for release; no further pulses.
  - sigIn=0 -> IDLE, cnt<=0. Releasing a long press never produces shortPress.
- Latency:
  - longPress is high in the cycle after the edge that samples the LONG_CYCLES-th consecutive high.
  - shortPress is high in the cycle after the edge that samples the DBL_GAP-th consecutive low following the release.
  - doublePress is high in the cycle after the edge that samples the second release.
- Boundary: a gap of exactly DBL_GAP lows yields shortPress. A rise on the next sample starts a fresh PRESS1, not PRESS2.
- Boundary: a gap of DBL_GAP-1 lows followed by a high enters PRESS2.
- A press lasting LONG_CYCLES-1 samples is short.
- Reset mid-gesture aborts the gesture with no pulse. If sigIn=1 at reset release, it is treated as a new press from IDLE.
- cnt never exceeds max(LONG_CYCLES, DBL_GAP); there is no wrap-around.

Test Plan:
All scenarios use LONG_CYCLES=16, DBL_GAP=8 and a 10 ns clock.
1. Reset: rst=0 with sigIn toggling -> pressed, shortPress, longPress and doublePress all 0. After release with sigIn=0, no pulses occur.
2. Short press:
   - Stimulus: sigIn high 5 samples, then low.
   - Required: shortPress is a single 1-cycle pulse in the cycle after the 8th low sample. longPress and doublePress stay 0.
3. Long press:
   - Stimulus: sigIn high 20 samples, then low 20.
   - Required: longPress pulses once, in the cycle after the 16th high sample. No shortPress on release. A press of 15 samples instead yields shortPress only.
4. Double press:
   - Stimulus: sigIn high 4, low 3, high 4, then low.
   - Required: doublePress pulses once, in the cycle after the first low sample of the second release. shortPress never asserts.
5. Gap boundary:
   - Stimulus A: high 4, low exactly 8, high 4, low 8. Required: two shortPress pulses, no doublePress.
   - Stimulus B: same sequence with a gap of 7. Required: one doublePress pulse.
6. Reset mid-operation:
   - Stimulus: enter WAIT_GAP (high 4, low 3), then pulse rst low for 2 cycles while sigIn=0.
   - Required: no pulse. A subsequent high 4 / low 8 yields exactly one shortPress.
